uart_tx_sequencer: RTL
======================

Name: uart_tx_sequencer

Overview:
Transmit-side controller for the UART. It pops bytes from the downstream FIFO (show-ahead) and serialises each byte as a frame: start bit, 8 data bits, even parity bit, then stop bit(s). Frame format comes from CTRL (stop_bit_mode, msb_first, hw_flow_ctrl_en) and the UART_BIT_LENGTH register. It drives the TX line and raises the tx_started/tx_done IRQ pulses and the tx_status flag.

Parameters:
DATA_WIDTH, 8, data bits per frame; equals DFIFO_WIDTH.
BIT_LEN_WIDTH, 32, width of the bit-length (clocks per bit) input.
CTS_SYNC_STAGES, 2, flop stages in the cts_n_i synchroniser.

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, asynchronous, active-low
bit_length_i  in  BIT_LEN_WIDTH  clocks per bit, from UART_BIT_LENGTH
stop_bit_mode_i  in  2  00: 1 stop, 01: 1.5 stop, 10/11: 2 stop
msb_first_i  in  1  1: data sent MSB first
hw_flow_ctrl_en_i  in  1  1: gate frame start on CTS
cts_n_i  in  1  clear-to-send, active-low, asynchronous
dfifo_empty_i  in  1  downstream FIFO empty
dfifo_data_i  in  DATA_WIDTH  FIFO head word (show-ahead)
dfifo_rd_o  out  1  FIFO pop strobe, one cycle
tx_o  out  1  serial TX line, idle high
tx_busy_o  out  1  tx_status: 1 while a frame is on the line
irq_tx_started_o  out  1  one-cycle pulse on the first cycle of the start bit
irq_tx_done_o  out  1  one-cycle pulse on the last cycle of the stop bit(s)

Behaviour:
- Reset values:
  - tx_o = 1.
  - dfifo_rd_o, tx_busy_o, irq_* = 0.
  - FSM = IDLE; CTS synchroniser = 1 (not clear).
- Launch condition `go` = !dfifo_empty_i && (!hw_flow_ctrl_en_i || cts_sync == 0).
- When `go` holds in IDLE, or on the last stop cycle:
  - dfifo_rd_o = 1 for that cycle.
  - Capture dfifo_data_i, bit_length_i, stop_bit_mode_i and msb_first_i into the frame registers.
  - Next cycle the FSM enters START.
- Config changes mid-frame do not affect the frame in flight.
- Effective bit length L = (bit_length_i == 0) ? 1 : bit_length_i.
- Each bit holds tx_o for exactly L cycles, timed by a down-counter loaded with L-1.
- States and tx_o value:
  - IDLE: tx_o = 1.
  - START: tx_o = 0, L cycles.
  - DATA: 8 bits, L cycles each. LSB first unless msb_first; an index counter runs 0..7 or 7..0.
  - PARITY: tx_o = XOR of the 8 data bits (even parity), L cycles.
  - STOP: tx_o = 1 for S cycles, where S = L (mode 00), L + (L>>1) (mode 01), or 2L (modes 10/11). Sum width is BIT_LEN_WIDTH+1; no overflow.
- Outputs are registered; tx_o changes on the clock edge that enters each state.
- irq_tx_started_o is asserted on the first START cycle.
- irq_tx_done_o is asserted on the final STOP cycle.
- tx_busy_o = 1 in START through STOP; otherwise 0.
- Back-to-back frames:
  - On the final STOP cycle, if `go` holds, pop and go straight to START. There is no idle gap.
  - irq_tx_done_o and dfifo_rd_o coincide; irq_tx_started_o follows on the next cycle.
  - tx_busy_o stays 1 across the boundary.
- Otherwise the final STOP cycle returns the FSM to IDLE.
- CTS: 2-flop synchroniser, sampled only at launch. Deasserting CTS mid-frame never aborts the frame. While hw_flow_ctrl_en_i = 0, CTS is ignored.
- FIFO empty: no pop and no activity; tx_o stays 1.
- Reset asserted mid-frame: tx_o goes high asynchronously and the frame is abandoned; the FIFO is not re-popped.
- Total frame length = 10L + S cycles from the first start cycle to the last stop cycle inclusive.

Decomposition:
- Into uart_pkg:
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - STOP_1 / STOP_1P5 / STOP_2 encodings for the 2-bit field;
  - UART_FRAME_DATA_BITS = 8.
- Sub-module uart_bit_timer:
  - loadable down-counter with load value and one-cycle `expire` output;
  - also reused later by the receiver.

Test Plan:
1. L=4, mode 00, LSB first, 0xA5 pushed:
   - tx_o = 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each bit for 4 cycles (44 cycles total);
   - irq_tx_started_o at cycle 0, irq_tx_done_o at cycle 43, one dfifo_rd_o.
2. L=3, msb_first=1, 0x01:
   - data bits 0,0,0,0,0,0,0,1, parity 1;
   - tx_busy_o high for exactly 33 cycles.
3. L=5, mode 01:
   - stop level lasts 7 cycles; mode 10 gives 10 cycles; bit_length_i = 0 gives 1-cycle bits.
4. Two bytes 0x55, 0x0F queued, L=2:
   - second start bit on the cycle after the first frame's last stop cycle;
   - dfifo_rd_o coincides with irq_tx_done_o; tx_busy_o never drops.
5. hw_flow_ctrl_en=1, cts_n=1, FIFO non-empty:
   - no pop, tx_o stays 1;
   - cts_n falls → pop 2 cycles later (sync), START on the next cycle;
   - cts_n rising mid-frame → frame completes.
6. rstn_i low at the 3rd DATA bit:
   - tx_o = 1 immediately, outputs reach reset values;
   - after release with FIFO empty, tx_o stays 1 and there is no IRQ.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants: TX FSM states, stop-bit encodings, frame size.
package uart_pkg;

  localparam int unsigned UART_FRAME_DATA_BITS = 8;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that times UART bit periods; shared by TX and RX.
module uart_bit_timer #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expire_o,
  output logic             expire_next_c
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load wins over decrement; the count rests at zero once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  assign expire_next_c = (cnt_d == '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q    <= '0;
      expire_o <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      expire_o <= expire_next_c;
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pops FIFO bytes and serialises start/data/parity/stop frames.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = UART_FRAME_DATA_BITS,
  parameter int unsigned BIT_LEN_WIDTH   = 32,
  parameter int unsigned CTS_SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [BIT_LEN_WIDTH-1:0] bit_length_i,
  input  logic [1:0]               stop_bit_mode_i,
  input  logic                     msb_first_i,
  input  logic                     hw_flow_ctrl_en_i,
  input  logic                     cts_n_i,
  input  logic                     dfifo_empty_i,
  input  logic [DATA_WIDTH-1:0]    dfifo_data_i,
  output logic                     dfifo_rd_o,
  output logic                     tx_o,
  output logic                     tx_busy_o,
  output logic                     irq_tx_started_o,
  output logic                     irq_tx_done_o
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W = BIT_LEN_WIDTH + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  tx_state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [BIT_LEN_WIDTH-1:0] len_q, len_d;
  logic [1:0]               stop_mode_q, stop_mode_d;
  logic                     msb_q, msb_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CTS_SYNC_STAGES-1:0] cts_sync_q;
  logic                     tx_d;
  logic                     go, launch;
  logic                     timer_load, timer_expire, timer_expire_next;
  logic [CNT_W-1:0]         timer_val, len_ext, len_in_ext, stop_len;
  logic [BIT_LEN_WIDTH-1:0] len_in;

  // CTS is asynchronous; it only matters at launch so plain flop stages suffice.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cts_sync_q <= '1;
    end else begin
      cts_sync_q <= {cts_sync_q[CTS_SYNC_STAGES-2:0], cts_n_i};
    end
  end

  assign len_in     = (bit_length_i == '0) ? BIT_LEN_WIDTH'(1) : bit_length_i;
  assign len_in_ext = CNT_W'(len_in);
  assign len_ext    = CNT_W'(len_q);

  // Stop duration in clocks, one bit wider than the bit length so 2L cannot wrap.
  always_comb begin
    case (stop_mode_q)
      STOP_1:   stop_len = len_ext;
      STOP_1P5: stop_len = len_ext + (len_ext >> 1);
      default:  stop_len = len_ext << 1;
    endcase
  end

  assign go = rstn_i && !dfifo_empty_i &&
              (!hw_flow_ctrl_en_i || !cts_sync_q[CTS_SYNC_STAGES-1]);

  // Pop must coincide with the capture of the show-ahead head word.
  assign dfifo_rd_o = launch;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    len_d       = len_q;
    stop_mode_d = stop_mode_q;
    msb_d       = msb_q;
    idx_d       = idx_q;
    launch      = 1'b0;
    timer_load  = 1'b0;
    timer_val   = len_ext - CNT_W'(1);

    case (state_q)
      IDLE: launch = go;
      START: begin
        if (timer_expire) begin
          state_d    = DATA;
          timer_load = 1'b1;
          idx_d      = msb_q ? IDX_LAST : IDX_W'(0);
        end
      end
      DATA: begin
        if (timer_expire) begin
          timer_load = 1'b1;
          if (idx_q == (msb_q ? IDX_W'(0) : IDX_LAST)) begin
            state_d = PARITY;
          end else begin
            idx_d = msb_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (timer_expire) begin
          state_d    = STOP;
          timer_load = 1'b1;
          timer_val  = stop_len - CNT_W'(1);
        end
      end
      STOP: begin
        if (timer_expire) begin
          state_d = IDLE;
          launch  = go;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame parameters are frozen at launch so mid-frame config edits are harmless.
    if (launch) begin
      state_d     = START;
      data_d      = dfifo_data_i;
      len_d       = len_in;
      stop_mode_d = stop_bit_mode_i;
      msb_d       = msb_first_i;
      timer_load  = 1'b1;
      timer_val   = len_in_ext - CNT_W'(1);
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      PARITY:  tx_d = ^data_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= IDLE;
      data_q           <= '0;
      len_q            <= BIT_LEN_WIDTH'(1);
      stop_mode_q      <= STOP_1;
      msb_q            <= 1'b0;
      idx_q            <= '0;
      tx_o             <= 1'b1;
      tx_busy_o        <= 1'b0;
      irq_tx_started_o <= 1'b0;
      irq_tx_done_o    <= 1'b0;
    end else begin
      state_q          <= state_d;
      data_q           <= data_d;
      len_q            <= len_d;
      stop_mode_q      <= stop_mode_d;
      msb_q            <= msb_d;
      idx_q            <= idx_d;
      tx_o             <= tx_d;
      tx_busy_o        <= (state_d != IDLE);
      irq_tx_started_o <= (state_d == START) && (state_q != START);
      irq_tx_done_o    <= (state_d == STOP) && timer_expire_next;
    end
  end

  uart_bit_timer #(
    .WIDTH(CNT_W)
  ) u_bit_timer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .load_i       (timer_load),
    .load_val_i   (timer_val),
    .expire_o     (timer_expire),
    .expire_next_c(timer_expire_next)
  );

endmodule
